// File: rtl/rgb565_gray_pack_ci.sv
// rgb565_gray_pack_ci
// Custom instruction: converts four RGB565 pixels (two per operand word) to
// 8-bit grayscale, one pixel per clock through a single shift-add datapath,
// and returns the four gray bytes packed into one 32-bit result word.
module rgb565_gray_pack_ci #(
  parameter logic [7:0] customInstructionId = 8'd0,
  parameter logic       bigEndianPack       = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  isId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_operand;
  logic [31:0] r_pack;
  logic [1:0]  r_cnt;
  logic        r_done;
  logic [31:0] r_result;

  logic        w_accept;
  logic        w_last;
  logic [15:0] w_pixel;
  logic [15:0] w_r6;
  logic [15:0] w_g6;
  logic [15:0] w_b6;
  logic [15:0] w_sum;
  logic [7:0]  w_gray;
  logic [1:0]  w_lane;
  logic [31:0] w_pack_next;

  assign w_accept = start && (isId == customInstructionId) && (r_state == S_IDLE);
  assign w_last   = (r_state == S_CONV) && (r_cnt == 2'd3);

  // Pixel cnt sits at bit offset 16*cnt of the latched operand pair.
  assign w_pixel = r_operand[{r_cnt, 4'b0000} +: 16];

  // Expand 5-bit red/blue to 6 bits so all three channels share one scale.
  assign w_r6 = {10'd0, w_pixel[15:11], 1'b0};
  assign w_g6 = {10'd0, w_pixel[10:5]};
  assign w_b6 = {10'd0, w_pixel[4:0], 1'b0};

  // 54*r + 183*g + 19*b as shifts and adds; peak value 16055 fits in 14 bits.
  assign w_sum = (w_r6 << 5) + (w_r6 << 4) + (w_r6 << 2) + (w_r6 << 1)
               + (w_g6 << 7) + (w_g6 << 5) + (w_g6 << 4) + (w_g6 << 2)
               + (w_g6 << 1) + w_g6
               + (w_b6 << 4) + (w_b6 << 1) + w_b6;

  // Divide by 64 with truncation; the weights sum to 256 over 6-bit channels.
  assign w_gray = 8'(w_sum >> 6);

  // Big-endian packing mirrors the lane order: lane 3-cnt equals ~cnt.
  assign w_lane = bigEndianPack ? ~r_cnt : r_cnt;

  // Replace only the lane being converted this cycle; other lanes keep their bytes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_pack_next[8*gi +: 8] = (w_lane == 2'(gi)) ? w_gray : r_pack[8*gi +: 8];
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE -> CONV on accept, four CONV cycles, one DONE cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_CONV;
      S_CONV:  if (r_cnt == 2'd3) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand latch, pixel counter, pack accumulator and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_operand <= 64'd0;
      r_pack    <= 32'd0;
      r_cnt     <= 2'd0;
      r_done    <= 1'b0;
      r_result  <= 32'd0;
    end else begin
      if (w_accept) begin
        r_operand <= {valueB, valueA};
        r_pack    <= 32'd0;
        r_cnt     <= 2'd0;
      end else if (r_state == S_CONV) begin
        r_pack <= w_pack_next;
        r_cnt  <= r_cnt + 2'd1;
      end
      // The output word is loaded only on the cycle that enters DONE, so it
      // is zero everywhere else and never shows a partially packed value.
      r_done   <= w_last;
      r_result <= w_last ? w_pack_next : 32'd0;
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_rgb565_gray_pack_ci.sv
// Testbench for rgb565_gray_pack_ci: little- and big-endian instances share
// stimulus; expected words go into per-instance queues and a negedge monitor
// pops and compares them whenever done is seen.
module tb_rgb565_gray_pack_ci;

  localparam logic [7:0] ID = 8'h2C;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  isId;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done_le;
  logic        done_be;
  logic [31:0] result_le;
  logic [31:0] result_be;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q_le[$];
  exp_t q_be[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  rgb565_gray_pack_ci #(.customInstructionId(ID), .bigEndianPack(1'b0)) dut_le (
    .clock(clock), .reset(reset), .start(start), .isId(isId),
    .valueA(valueA), .valueB(valueB), .done(done_le), .result(result_le)
  );

  rgb565_gray_pack_ci #(.customInstructionId(ID), .bigEndianPack(1'b1)) dut_be (
    .clock(clock), .reset(reset), .start(start), .isId(isId),
    .valueA(valueA), .valueB(valueB), .done(done_be), .result(result_be)
  );

  // Reference conversion written with plain multiplies.
  function automatic logic [7:0] gray_ref(input logic [15:0] p);
    int r6;
    int g6;
    int b6;
    int s;
    r6 = int'(p[15:11]) * 2;
    g6 = int'(p[10:5]);
    b6 = int'(p[4:0]) * 2;
    s  = 54 * r6 + 183 * g6 + 19 * b6;
    return 8'(s / 64);
  endfunction

  function automatic logic [31:0] pack_ref(input logic [31:0] a, input logic [31:0] b,
                                           input bit be);
    logic [7:0] g0;
    logic [7:0] g1;
    logic [7:0] g2;
    logic [7:0] g3;
    g0 = gray_ref(a[15:0]);
    g1 = gray_ref(a[31:16]);
    g2 = gray_ref(b[15:0]);
    g3 = gray_ref(b[31:16]);
    return be ? {g0, g1, g2, g3} : {g3, g2, g1, g0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a matching start; the done pulse is due five cycles later.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_le, input logic [31:0] exp_be);
    exp_t e;
    start  = 1'b1;
    isId   = ID;
    valueA = a;
    valueB = b;
    e.cyc  = cyc + 5;
    e.data = exp_le;
    q_le.push_back(e);
    e.data = exp_be;
    q_be.push_back(e);
    tick();
    start = 1'b0;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_le, input logic [31:0] exp_be);
    issue(a, b, exp_le, exp_be);
    repeat (5) tick();
  endtask

  task automatic check_port(input bit be, input logic d, input logic [31:0] r);
    exp_t e;
    string nm;
    nm = be ? "be" : "le";
    if (d === 1'b1) begin
      if ((be ? q_be.size() : q_le.size()) == 0) begin
        n_err++;
        $display("FAIL unexpected_done_%s cyc=%0d result=%08h required no done", nm, cyc, r);
      end else begin
        e = be ? q_be.pop_front() : q_le.pop_front();
        n_vec++;
        if (r !== e.data || cyc != e.cyc) begin
          n_err++;
          $display("FAIL result_%s got %08h at cyc %0d, required %08h at cyc %0d",
                   nm, r, cyc, e.data, e.cyc);
        end else begin
          $display("vector %s cyc=%0d result=%08h ok", nm, cyc, r);
        end
      end
    end else if (d !== 1'b0 || r !== 32'd0) begin
      n_err++;
      $display("FAIL idle_zero_%s cyc=%0d done=%b result=%08h required done=0 result=00000000",
               nm, cyc, d, r);
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clock) begin
    if (mon_en) begin
      check_port(1'b0, done_le, result_le);
      check_port(1'b1, done_be, result_be);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d required finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    reset  = 1'b1;
    start  = 1'b0;
    isId   = 8'h00;
    valueA = 32'd0;
    valueB = 32'd0;
    repeat (3) tick();
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Basic vectors with hand-computed results.
    run(32'h07E0F800, 32'hFFFF001F, 32'hFA12B434, 32'h34B412FA);
    run(32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000);
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFAFAFAFA, 32'hFAFAFAFA);

    // Non-matching id: no done for ten cycles.
    start  = 1'b1;
    isId   = ID + 8'd1;
    valueA = 32'h07E0F800;
    valueB = 32'hFFFF001F;
    tick();
    start = 1'b0;
    repeat (10) tick();

    // Matching start while busy is ignored.
    issue(32'h07E0F800, 32'hFFFF001F, 32'hFA12B434, 32'h34B412FA);
    tick();
    start  = 1'b1;
    isId   = ID;
    valueA = 32'hFFFFFFFF;
    valueB = 32'hFFFFFFFF;
    tick();
    start = 1'b0;
    repeat (3) tick();

    // Operands scrambled every cycle after accept.
    issue(32'hF800F800, 32'h07E007E0, 32'hB4B43434, 32'h3434B4B4);
    for (int i = 0; i < 5; i++) begin
      valueA = $urandom;
      valueB = $urandom;
      tick();
    end

    // Reset during the third CONV cycle discards the operation.
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFAFAFAFA, 32'hFAFAFAFA);
    tick();
    tick();
    reset = 1'b1;
    q_le.delete();
    q_be.delete();
    tick();
    reset = 1'b0;
    repeat (6) tick();
    run(32'h001F07E0, 32'hF800FFFF, 32'h34FA12B4, 32'hB412FA34);

    // Random regression against the reference model.
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      run(a, b, pack_ref(a, b, 1'b0), pack_ref(a, b, 1'b1));
    end

    repeat (10) tick();
    if (q_le.size() != 0 || q_be.size() != 0) begin
      n_err++;
      $display("FAIL missing_done pending le=%0d be=%0d required 0", q_le.size(), q_be.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
